branch_predictor: RTL and testbench

Parametrised branch prediction and resolution unit for the RV32E core. Fetch queries a direct-mapped table of 2-bit saturating counters with tagged targets to obtain a next-PC guess. Execute reports each resolved conditional branch or jump, and the unit trains the table. One cycle later it raises a registered mispredict/redirect to the front end. It sits between fetch (lookup port) and the execute-stage branch condition logic (update port).

---
 rtl/branch_pkg.sv | 41 ++++
 rtl/bp_table.sv | 54 +++++
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction unit: 2-bit counter
// encoding, table entry layout, saturating counter update and the branch
// condition (funct3) constants used by the execute-stage compare logic.
package branch_pkg;

  // Entry fields are sized for the widest supported address; narrower
  // builds zero-extend tags and targets into them.
  localparam int BP_XLEN = 32;

  localparam logic [2:0] BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] BRANCH_BNE  = 3'b001;
  localparam logic [2:0] BRANCH_BLT  = 3'b100;
  localparam logic [2:0] BRANCH_BGE  = 3'b101;
  localparam logic [2:0] BRANCH_BLTU = 3'b110;
  localparam logic [2:0] BRANCH_BGEU = 3'b111;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic                valid;
    logic [BP_XLEN-1:0]  tag;
    logic [BP_XLEN-1:0]  target;
    bp_ctr_e             ctr;
  } bp_entry_t;

  localparam bp_entry_t BP_ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic bp_ctr_e ctr_next(input bp_ctr_e c, input logic taken);
    if (taken) begin
      return (c == STRONG_T) ? STRONG_T : bp_ctr_e'(c + 2'd1);
    end
    return (c == STRONG_NT) ? STRONG_NT : bp_ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped prediction table: one combinational read port for fetch and
// one training port that read-modify-writes the addressed entry on the edge.
module bp_table
  import branch_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output bp_entry_t           rd_entry,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [BP_XLEN-1:0]  wr_tag,
  input  logic                wr_taken,
  input  logic [BP_XLEN-1:0]  wr_target
);

  bp_entry_t table_q [ENTRIES];
  bp_entry_t table_d [ENTRIES];
  bp_entry_t wr_cur;

  // Read port sees registered contents, so a same-cycle write is not visible.
  assign rd_entry = table_q[rd_idx];

  // Training: hit adjusts counter (and target when taken); taken miss allocates.
  always_comb begin
    table_d = table_q;
    wr_cur  = table_q[wr_idx];
    if (wr_en) begin
      if (wr_cur.valid && (wr_cur.tag == wr_tag)) begin
        table_d[wr_idx].ctr = ctr_next(wr_cur.ctr, wr_taken);
        if (wr_taken) begin
          table_d[wr_idx].target = wr_target;
        end
      end else if (wr_taken) begin
        table_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: WEAK_T};
      end
    end
  end

  // Table storage; reset wins over a same-cycle training write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= BP_ENTRY_RESET;
      end
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction and resolution unit. Fetch gets a combinational
// next-PC guess; execute reports resolved branches, which train the table
// and raise a registered mispredict/redirect one cycle later.
// Optional feature macro: BP_STATS_EN adds branch/mispredict counters.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_pred_taken,
  input  logic [XLEN-1:0] update_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_addr
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  bp_entry_t            rd_entry;
  logic [IDX_BITS-1:0]  lookup_idx;
  logic [BP_XLEN-1:0]   lookup_tag;
  logic                 lookup_hit;
  logic [IDX_BITS-1:0]  upd_idx;
  logic [BP_XLEN-1:0]   upd_tag;
  logic                 mispredict_cond;
  logic [XLEN-1:0]      redirect_calc;
  logic                 mispredict_d, mispredict_q;
  logic [XLEN-1:0]      redirect_d, redirect_q;

  assign lookup_idx = lookup_pc[IDX_BITS+1:2];
  assign lookup_tag = BP_XLEN'(lookup_pc >> (IDX_BITS + 2));
  assign upd_idx    = update_pc[IDX_BITS+1:2];
  assign upd_tag    = BP_XLEN'(update_pc >> (IDX_BITS + 2));

  bp_table #(
    .ENTRIES  (ENTRIES),
    .IDX_BITS (IDX_BITS)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lookup_idx),
    .rd_entry  (rd_entry),
    .wr_en     (update_valid),
    .wr_idx    (upd_idx),
    .wr_tag    (upd_tag),
    .wr_taken  (update_taken),
    .wr_target (BP_XLEN'(update_target))
  );

  // Fetch-side prediction; fall through to pc+4 when not predicted taken.
  always_comb begin
    lookup_hit     = rd_entry.valid && (rd_entry.tag == lookup_tag);
    predict_taken  = lookup_hit && rd_entry.ctr[1];
    predict_target = predict_taken ? XLEN'(rd_entry.target) : lookup_pc + XLEN'(4);
  end

  // Resolution check and next-state for the registered redirect.
  always_comb begin
    mispredict_cond = update_valid &&
                      ((update_taken != update_pred_taken) ||
                       (update_taken && (update_target != update_pred_target)));
    redirect_calc   = update_taken ? update_target : update_pc + XLEN'(4);
    mispredict_d    = mispredict_cond;
    redirect_d      = mispredict_cond ? redirect_calc : redirect_q;
  end

  // Redirect registers; reset drops any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  assign mispredict    = mispredict_q;
  assign redirect_addr = redirect_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_d, stat_branches_q;
  logic [31:0] stat_mispredicts_d, stat_mispredicts_q;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, update_valid};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict_cond};
  end

  // Counter registers, updated on the same edge as mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor (ENTRIES=16, XLEN=32). Stats checks are
// included when BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        mispredict;
  logic [31:0] redirect_addr;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .lookup_pc          (lookup_pc),
    .predict_taken      (predict_taken),
    .predict_target     (predict_target),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .mispredict         (mispredict),
    .redirect_addr      (redirect_addr)
`ifdef BP_STATS_EN
    ,
    .stat_branches      (stat_branches),
    .stat_mispredicts   (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic [31:0] lpc;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_m;
    logic [31:0] e_r;
  } vec_t;

  typedef struct {
    logic        m;
    logic [31:0] r;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_upd  = 0;
  int   n_misp = 0;

  function automatic vec_t mk(logic uv, logic [31:0] pc, logic tk, logic [31:0] tgt,
                              logic pt, logic [31:0] ptgt, logic [31:0] lpc,
                              logic e_pt, logic [31:0] e_ptgt, logic e_m, logic [31:0] e_r);
    vec_t v;
    v.uv = uv; v.pc = pc; v.tk = tk; v.tgt = tgt; v.pt = pt; v.ptgt = ptgt;
    v.lpc = lpc; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_m = e_m; v.e_r = e_r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    update_valid       = 1'b0;
    update_pc          = '0;
    update_taken       = 1'b0;
    update_target      = '0;
    update_pred_taken  = 1'b0;
    update_pred_target = '0;
  endtask

  // One cycle: drive update + lookup, check lookup, push expected redirect,
  // clock, then pop and compare the registered outputs.
  task automatic apply(input int n, input vec_t v);
    sb_t e;
    update_valid       = v.uv;
    update_pc          = v.pc;
    update_taken       = v.tk;
    update_target      = v.tgt;
    update_pred_taken  = v.pt;
    update_pred_target = v.ptgt;
    lookup_pc          = v.lpc;
    #1;
    chk($sformatf("v%0d predict_taken", n), {31'd0, predict_taken}, {31'd0, v.e_pt});
    chk($sformatf("v%0d predict_target", n), predict_target, v.e_ptgt);
    sb.push_back('{m: v.e_m, r: v.e_r});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL v%0d scoreboard empty actual=0 required=1", n);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d mispredict", n), {31'd0, mispredict}, {31'd0, e.m});
      if (e.m) chk($sformatf("v%0d redirect_addr", n), redirect_addr, e.r);
    end
    drive_idle();
  endtask

  initial begin
    //             uv  pc            tk  tgt           pt  ptgt          lookup        e_pt e_ptgt       e_m e_r
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h100,      0, 32'h104,      0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      1, 32'h80,      0, 32'h104,     32'h100,      0, 32'h104,      1, 32'h80));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h100,      1, 32'h80,       0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      1, 32'h80,      1, 32'h80,      32'h100,      1, 32'h80,       0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      1, 32'h80,      1, 32'h80,      32'h100,      1, 32'h80,       0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      1, 32'h80,      1, 32'h80,      32'h100,      1, 32'h80,       0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      0, 32'h0,       1, 32'h80,      32'h100,      1, 32'h80,       1, 32'h104));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h100,      1, 32'h80,       0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      0, 32'h0,       1, 32'h80,      32'h100,      1, 32'h80,       1, 32'h104));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h100,      0, 32'h104,      0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      1, 32'h80,      0, 32'h104,     32'h100,      0, 32'h104,      1, 32'h80));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h140,      0, 32'h144,      0, 32'h0));
    vecs.push_back(mk(1, 32'h140,      1, 32'h200,     0, 32'h144,     32'h100,      1, 32'h80,       1, 32'h200));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h100,      0, 32'h104,      0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h140,      1, 32'h200,      0, 32'h0));
    vecs.push_back(mk(1, 32'h140,      1, 32'h90,      1, 32'h200,     32'h140,      1, 32'h200,      1, 32'h90));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 32'h0,       32'h140,      1, 32'h90,       0, 32'h0));
    vecs.push_back(mk(1, 32'h300,      0, 32'h0,       0, 32'h0,       32'h300,      0, 32'h304,      0, 32'h0));
    vecs.push_back(mk(1, 32'hFFFFFFFC, 0, 32'h0,       1, 32'h40,      32'hFFFFFFFC, 0, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1, 32'h104,      0, 32'h0,       0, 32'h0,       32'h300,      0, 32'h304,      0, 32'h0));
    vecs.push_back(mk(1, 32'h104,      1, 32'h10,      0, 32'h108,     32'h104,      0, 32'h108,      1, 32'h10));
    vecs.push_back(mk(1, 32'h108,      1, 32'h20,      0, 32'h10C,     32'h104,      1, 32'h10,       1, 32'h20));

    rst = 1'b1;
    lookup_pc = 32'h100;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset mispredict", {31'd0, mispredict}, 32'd0);
    chk("reset redirect_addr", redirect_addr, 32'd0);
`ifdef BP_STATS_EN
    chk("reset stat_branches", stat_branches, 32'd0);
    chk("reset stat_mispredicts", stat_mispredicts, 32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
      if (vecs[i].uv) n_upd++;
      if (vecs[i].e_m) n_misp++;
    end

`ifdef BP_STATS_EN
    chk("stat_branches", stat_branches, n_upd);
    chk("stat_mispredicts", stat_mispredicts, n_misp);
`endif

    // Reset coincident with a taken, mispredicted update at 0x200.
    update_valid       = 1'b1;
    update_pc          = 32'h200;
    update_taken       = 1'b1;
    update_target      = 32'h40;
    update_pred_taken  = 1'b0;
    update_pred_target = 32'h204;
    rst                = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    chk("rst+update mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst+update redirect_addr", redirect_addr, 32'd0);
`ifdef BP_STATS_EN
    chk("rst stat_branches", stat_branches, 32'd0);
    chk("rst stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    lookup_pc = 32'h200;
    #1;
    chk("rst no alloc predict_taken", {31'd0, predict_taken}, 32'd0);
    chk("rst no alloc predict_target", predict_target, 32'h204);
    lookup_pc = 32'h140;
    #1;
    chk("rst cleared 0x140 predict_taken", {31'd0, predict_taken}, 32'd0);
    chk("rst cleared 0x140 predict_target", predict_target, 32'h144);

    // Five updates with two mispredicts after reset.
    apply(100, mk(1, 32'h100, 1, 32'h80, 0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80));
    apply(101, mk(1, 32'h100, 1, 32'h80, 1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h0));
    apply(102, mk(1, 32'h100, 1, 32'h84, 1, 32'h80,  32'h100, 1, 32'h80,  1, 32'h84));
    apply(103, mk(1, 32'h108, 0, 32'h0,  0, 32'h0,   32'h100, 1, 32'h84,  0, 32'h0));
    apply(104, mk(1, 32'h100, 1, 32'h84, 1, 32'h84,  32'h100, 1, 32'h84,  0, 32'h0));
    apply(105, mk(0, 32'h0,   0, 32'h0,  0, 32'h0,   32'h100, 1, 32'h84,  0, 32'h0));
`ifdef BP_STATS_EN
    chk("stat_branches 5", stat_branches, 32'd5);
    chk("stat_mispredicts 2", stat_mispredicts, 32'd2);
`endif

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard leftover actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
